// File: rtl/adc16dv160_packet_framer.sv
// AXI-Stream packet framer: wraps each input packet in a 4-word header
// (magic, seq, expected size, timestamp) and a 1-word length/mismatch trailer.
module adc16dv160_packet_framer #(
  parameter logic [31:0] MAGIC    = 32'hADC16D16,
  parameter int unsigned TS_WIDTH = 32
) (
  input  logic        s00_axis_aclk,
  input  logic        s00_axis_aresetn,
  input  logic        s00_axis_tvalid,
  input  logic [31:0] s00_axis_tdata,
  input  logic [3:0]  s00_axis_tkeep,
  input  logic        s00_axis_tlast,
  output logic        s00_axis_tready,
  output logic        m00_axis_tvalid,
  output logic [31:0] m00_axis_tdata,
  output logic [3:0]  m00_axis_tkeep,
  output logic        m00_axis_tlast,
  input  logic        m00_axis_tready,
  input  logic        enable,
  input  logic [31:0] dsize,
  input  logic        ts_clear,
  output logic [31:0] pkt_count,
  output logic        err_len
);

  typedef enum logic [2:0] {IDLE, H0, H1, H2, H3, PAY, TRL, DONE} state_t;

  state_t              state_q;
  logic [TS_WIDTH-1:0] ts_q, ts_l_q;
  logic [31:0]         dsz_l_q, seq_q, tdata_q;
  logic [30:0]         cnt_q, cnt_d;
  logic                mis_q, mis_d, err_q, tvalid_q, tlast_q;
  logic                ld, in_hs, out_done;
  logic                unused_tkeep;

  assign unused_tkeep = ^s00_axis_tkeep;

  // Output register may take a new word when empty or being drained this cycle.
  assign ld       = !tvalid_q || m00_axis_tready;
  assign in_hs    = (state_q == PAY) && ld && s00_axis_tvalid;
  assign out_done = tvalid_q && m00_axis_tready && tlast_q;

  always_comb begin
    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 31'd1;
    mis_d = (cnt_q == '1) || ({1'b0, cnt_q} != dsz_l_q);
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (!s00_axis_aresetn) begin
      state_q  <= IDLE;
      ts_q     <= '0;
      ts_l_q   <= '0;
      dsz_l_q  <= '0;
      seq_q    <= '0;
      tdata_q  <= '0;
      cnt_q    <= '0;
      mis_q    <= 1'b0;
      err_q    <= 1'b0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      ts_q <= ts_clear ? '0 : ts_q + TS_WIDTH'(1);
      // Drain by default; any state that loads a word below overrides this.
      if (ld) tvalid_q <= 1'b0;
      case (state_q)
        IDLE: if (enable && s00_axis_tvalid) begin
          dsz_l_q <= dsize;
          ts_l_q  <= ts_q;
          state_q <= H0;
        end
        H0: if (ld) begin
          tvalid_q <= 1'b1; tdata_q <= MAGIC;   tlast_q <= 1'b0; state_q <= H1;
        end
        H1: if (ld) begin
          tvalid_q <= 1'b1; tdata_q <= seq_q;   tlast_q <= 1'b0; state_q <= H2;
        end
        H2: if (ld) begin
          tvalid_q <= 1'b1; tdata_q <= dsz_l_q; tlast_q <= 1'b0; state_q <= H3;
        end
        H3: if (ld) begin
          tvalid_q <= 1'b1; tdata_q <= 32'(ts_l_q); tlast_q <= 1'b0; state_q <= PAY;
        end
        PAY: if (in_hs) begin
          tvalid_q <= 1'b1;
          tdata_q  <= s00_axis_tdata;
          tlast_q  <= 1'b0;
          cnt_q    <= cnt_d;
          if (s00_axis_tlast) state_q <= TRL;
        end
        TRL: if (ld) begin
          tvalid_q <= 1'b1;
          tdata_q  <= {mis_d, cnt_q};
          tlast_q  <= 1'b1;
          mis_q    <= mis_d;
          state_q  <= DONE;
        end
        DONE: if (out_done) begin
          seq_q   <= seq_q + 32'd1;
          err_q   <= err_q | mis_q;
          cnt_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s00_axis_tready = (state_q == PAY) && ld;
  assign m00_axis_tvalid = tvalid_q;
  assign m00_axis_tdata  = tdata_q;
  assign m00_axis_tlast  = tlast_q;
  assign m00_axis_tkeep  = 4'b1111;
  assign pkt_count       = seq_q;
  assign err_len         = err_q;

endmodule
